// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the pin-boundary input conditioner.
// Pure declarations; no timing or flow-control implications.
package input_cond_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so DEBOUNCE_CYCLES-1 always fits.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: sync chain, consecutive-sample debounce, edge detect.
// Latency SYNC_DEPTH+DEBOUNCE_CYCLES edges to level; pulses follow level; no backpressure.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_DEPTH      = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic async_in,
    input  logic en_i,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_out;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_d;

    generate
        if (SYNC_DEPTH == 0) begin : g_bypass
            assign sync_out = async_in;
        end else begin : g_sync
            logic [SYNC_DEPTH-1:0] sync_q;

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    sync_q <= {SYNC_DEPTH{RESET_VAL}};
                end else begin
                    sync_q[0] <= async_in;
                    for (int i = 1; i < SYNC_DEPTH; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign sync_out = sync_q[SYNC_DEPTH-1];
        end
    endgenerate

    // stable_d runs regardless of en_i so an accepted edge always yields its pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= '0;
            stable   <= RESET_VAL;
            stable_d <= RESET_VAL;
        end else begin
            stable_d <= stable;
            if (!en_i) begin
                cnt <= '0;
            end else if (sync_out == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_out;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level_out = stable;
    assign rise_out  = stable & ~stable_d;
    assign fall_out  = ~stable & stable_d;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for asynchronous pins: clean level plus rise/fall/event pulses.
// Latency SYNC_DEPTH+DEBOUNCE_CYCLES edges; free-running, no backpressure.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_DEPTH      = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0,
    parameter edge_mode_t       EDGE_MODE       = EDGE_RISE
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             en_i,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic [WIDTH-1:0] event_out
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_channel #(
                .SYNC_DEPTH      (SYNC_DEPTH),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RESET_VAL[i])
            ) u_chan (
                .clk       (clk),
                .nrst      (nrst),
                .async_in  (async_in[i]),
                .en_i      (en_i),
                .level_out (level_out[i]),
                .rise_out  (rise_out[i]),
                .fall_out  (fall_out[i])
            );
        end
    endgenerate

    always_comb begin
        event_out = rise_out;
        case (EDGE_MODE)
            EDGE_FALL: event_out = fall_out;
            EDGE_BOTH: event_out = rise_out | fall_out;
            default:   event_out = rise_out;
        endcase
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: directed steps push hand-computed expectations, a monitor pops and compares.
// DUT A: SYNC_DEPTH=2, DEBOUNCE_CYCLES=4, EDGE_BOTH. DUT B: SYNC_DEPTH=0, DEBOUNCE_CYCLES=1, EDGE_RISE.
module tb_input_conditioner;
    import input_cond_pkg::*;

    logic       clk  = 1'b0;
    logic       nrst = 1'b1;
    logic [3:0] a_in = 4'h0;
    logic [3:0] b_in = 4'h0;
    logic       en_a = 1'b1;
    logic       en_b = 1'b1;
    logic [3:0] lvl_a, rise_a, fall_a, evt_a;
    logic [3:0] lvl_b, rise_b, fall_b, evt_b;

    always #5 clk = ~clk;

    input_conditioner #(
        .WIDTH(4), .SYNC_DEPTH(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'h0), .EDGE_MODE(EDGE_BOTH)
    ) u_dut_a (
        .clk(clk), .nrst(nrst), .async_in(a_in), .en_i(en_a),
        .level_out(lvl_a), .rise_out(rise_a), .fall_out(fall_a), .event_out(evt_a)
    );

    input_conditioner #(
        .WIDTH(4), .SYNC_DEPTH(0), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'h0), .EDGE_MODE(EDGE_RISE)
    ) u_dut_b (
        .clk(clk), .nrst(nrst), .async_in(b_in), .en_i(en_b),
        .level_out(lvl_b), .rise_out(rise_b), .fall_out(fall_b), .event_out(evt_b)
    );

    typedef struct {
        logic [3:0] lvl, rise, fall, evt;
        logic [3:0] lvl_b, rise_b, fall_b, evt_b;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input string sig, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h (t=%0t)", name, sig, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the next rising edge.
    task automatic step(input logic en, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] lvl, input logic [3:0] rise, input logic [3:0] fall,
                        input logic [3:0] evt, input logic [3:0] lvlb, input logic [3:0] riseb,
                        input logic [3:0] fallb, input logic [3:0] evtb, input string name);
        exp_t e;
        en_a = en;
        a_in = a;
        b_in = b;
        e.lvl = lvl;     e.rise = rise;     e.fall = fall;     e.evt = evt;
        e.lvl_b = lvlb;  e.rise_b = riseb;  e.fall_b = fallb;  e.evt_b = evtb;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic quiet(input int n, input logic en, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] lvl, input logic [3:0] lvlb, input string name);
        repeat (n) step(en, a, b, lvl, 4'h0, 4'h0, 4'h0, lvlb, 4'h0, 4'h0, 4'h0, name);
    endtask

    task automatic push_reset(input string name);
        exp_t e;
        e.lvl = 4'h0;   e.rise = 4'h0;   e.fall = 4'h0;   e.evt = 4'h0;
        e.lvl_b = 4'h0; e.rise_b = 4'h0; e.fall_b = 4'h0; e.evt_b = 4'h0;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every edge, and immediately on async reset entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge nrst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "level_a", lvl_a,  e.lvl);
                chk(e.name, "rise_a",  rise_a, e.rise);
                chk(e.name, "fall_a",  fall_a, e.fall);
                chk(e.name, "event_a", evt_a,  e.evt);
                chk(e.name, "level_b", lvl_b,  e.lvl_b);
                chk(e.name, "rise_b",  rise_b, e.rise_b);
                chk(e.name, "fall_b",  fall_b, e.fall_b);
                chk(e.name, "event_b", evt_b,  e.evt_b);
            end
        end
    end

    initial begin
        a_in = 4'hF;
        #1;
        push_reset("reset_state");
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Rise on all channels after 6 edges, single-cycle pulse.
        quiet(5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, "t1_wait");
        step(1'b1, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "t1_rise");
        quiet(1, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, "t1_after");

        // Three-sample glitch on ch0 is rejected.
        quiet(3, 1'b1, 4'hE, 4'h0, 4'hF, 4'h0, "t2_glitch");
        quiet(4, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, "t2_recover");

        // ch1 fall on A; B ch3 steps high with single-edge latency.
        step(1'b1, 4'hD, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h8, "t3_start");
        quiet(4, 1'b1, 4'hD, 4'h8, 4'hF, 4'h8, "t3_wait");
        step(1'b1, 4'hD, 4'h8, 4'hD, 4'h0, 4'h2, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, "t3_fall");
        quiet(1, 1'b1, 4'hD, 4'h8, 4'hD, 4'h8, "t3_after");

        // ch2 counts to 3, enable drops for 2 cycles, then 4 fresh enabled edges are needed.
        // B ch3 falls: fall pulse but no event in rise mode.
        step(1'b1, 4'h9, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, "t4_bfall");
        quiet(4, 1'b1, 4'h9, 4'h0, 4'hD, 4'h0, "t4_count");
        quiet(2, 1'b0, 4'h9, 4'h0, 4'hD, 4'h0, "t4_disabled");
        quiet(3, 1'b1, 4'h9, 4'h0, 4'hD, 4'h0, "t4_reenabled");
        step(1'b1, 4'h9, 4'h0, 4'h9, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, "t4_fall");
        quiet(1, 1'b1, 4'h9, 4'h0, 4'h9, 4'h0, "t4_after");

        // ch2 rises back; reset lands between edges with its counter at 2.
        quiet(4, 1'b1, 4'hB, 4'h0, 4'h9, 4'h0, "t5_count");
        push_reset("t5_async_reset");
        #2;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        quiet(5, 1'b1, 4'hB, 4'h0, 4'h0, 4'h0, "t5_wait");
        step(1'b1, 4'hB, 4'h0, 4'hB, 4'hB, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, "t5_rise");
        quiet(1, 1'b1, 4'hB, 4'h0, 4'hB, 4'h0, "t5_after");

        // Zero-sync, one-cycle debounce after a reset.
        step(1'b1, 4'hB, 4'h8, 4'hB, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h8, "t6_rise");
        step(1'b1, 4'hB, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, "t6_fall");

        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Multi-channel conditioner for asynchronous inputs such as buttons, switches and external strobes.
Each channel passes through a parametrised synchronizer chain, then a consecutive-sample debounce filter, then edge detection.
Outputs are a clean level plus single-cycle rise, fall and selectable event pulses, all in the clk domain.
It sits at the chip-pin boundary, ahead of the game/control FSMs.

Parameters:
WIDTH, 4, number of independent channels (>=1)
SYNC_DEPTH, 2, synchronizer flops per channel; 0 = bypass (input already synchronous)
DEBOUNCE_CYCLES, 4, consecutive differing samples required to accept a new level (>=1)
RESET_VAL, 0, WIDTH-bit reset level for the sync chain and the debounced level
EDGE_MODE, EDGE_RISE, event_out source: EDGE_RISE, EDGE_FALL or EDGE_BOTH (from package)

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
async_in  input  WIDTH  raw asynchronous inputs
en_i  input  1  filter enable; low = freeze levels, clear counters
level_out  output  WIDTH  debounced level
rise_out  output  WIDTH  one-cycle pulse on accepted 0->1
fall_out  output  WIDTH  one-cycle pulse on accepted 1->0
event_out  output  WIDTH  rise_out, fall_out or their OR, per EDGE_MODE

Behaviour:
- Reset (nrst low, asynchronous):
  - sync flops, stable level and delayed-level register load RESET_VAL.
  - counters load 0.
  - all outputs settle immediately: level_out=RESET_VAL, rise/fall/event_out=0.
- No pulse is generated on reset release. The delayed-level register shares RESET_VAL.
- Sync stage: SYNC_DEPTH-flop shift chain per channel; sync_out = last flop. SYNC_DEPTH=0 makes sync_out = async_in.
- Debounce, per channel, evaluated on each clk edge:
  - en_i=0: counter<=0, stable held.
  - sync_out==stable: counter<=0.
  - sync_out!=stable and counter==DEBOUNCE_CYCLES-1: stable<=sync_out, counter<=0.
  - otherwise: counter<=counter+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Latency: a clean input change appears on level_out exactly SYNC_DEPTH+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Any reversion to the stable value before acceptance restarts the count from 0. A bounce shorter than DEBOUNCE_CYCLES produces no output activity.
- level_out = stable, registered.
- Edge outputs, combinational from registers:
  - stable_d <= stable every cycle.
  - rise_out = stable & ~stable_d; fall_out = ~stable & stable_d.
  - Each pulse is high for exactly the first cycle of the new level.
- Channels are fully independent. Simultaneous changes on several channels yield simultaneous pulses.
- Toggling en_i low mid-count discards progress. Acceptance requires DEBOUNCE_CYCLES consecutive enabled, differing samples after en_i returns high.
- en_i does not affect the sync chain or stable_d, so a pulse already in flight completes.

Decomposition:
- Package input_cond_pkg:
  - edge_mode_t enum (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2).
  - function cnt_width(DEBOUNCE_CYCLES).
- Sub-module debounce_channel (single-bit):
  - contains sync chain, counter, stable, stable_d and the edge logic.
  - instantiated WIDTH times in a generate loop.
  - top level only handles EDGE_MODE muxing and per-channel RESET_VAL bit slicing.

Test Plan:
1. WIDTH=4, SYNC_DEPTH=2, DEBOUNCE_CYCLES=4, RESET_VAL=0, en_i=1; drive async_in=4'hF during reset, then release -> level_out=0 for 5 edges; level_out=4'hF after edge 6; rise_out=4'hF for exactly one cycle; fall_out=0.
2. Glitch reject: after 1, ch0 low for 3 cycles, then high again -> level_out stays 4'hF; rise/fall/event_out all 0 throughout.
3. Fall with EDGE_MODE=EDGE_BOTH: ch1 held low -> level_out[1]=0 six edges later; fall_out[1]=1 and event_out[1]=1 for one cycle; other channels unchanged.
4. Enable gating: ch2 differs for 3 cycles, en_i=0 for 2 cycles, then en_i=1 -> level_out[2] changes only after 4 further enabled edges of unchanged input.
5. Reset mid-operation: assert nrst between clock edges with a counter at 2 -> outputs immediately become RESET_VAL/0; after release, no pulse; the full 6-edge latency is required again.
6. SYNC_DEPTH=0, DEBOUNCE_CYCLES=1: step async_in[3] -> level_out[3] and rise_out[3] update after exactly 1 edge.
